// File: rtl/picorv_mem_bridge.sv
// rtl/picorv_mem_bridge.sv - PicoRV32 native memory port to tagged cache request/response bridge.
// Optional response watchdog enabled by defining PICORV_MEM_BRIDGE_TIMEOUT_EN.
module picorv_mem_bridge #(
    parameter int TID_W          = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    input  logic [3:0]       mem_wstrb_i,
    output logic             mem_ready_o,
    output logic [31:0]      mem_rdata_o,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [31:0]      req_addr_o,
    output logic [31:0]      req_wdata_o,
    output logic [3:0]       req_be_o,
    output logic             req_is_store_o,
    output logic [TID_W-1:0] req_tid_o,
    input  logic             rsp_valid_i,
    input  logic [TID_W-1:0] rsp_tid_i,
    input  logic [31:0]      rsp_rdata_i,
    input  logic             rsp_error_i,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic [TID_W-1:0] tid_cnt;
    logic [TID_W-1:0] exp_tid;
    logic             rsp_match;

    // Only a response tagged with the single outstanding TID, seen in WAIT, completes a transaction.
    assign rsp_match = rsp_valid_i && (state == WAIT) && (rsp_tid_i == exp_tid);
    assign req_tid_o = tid_cnt;

`ifdef PICORV_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            mem_ready_o    <= 1'b0;
            mem_rdata_o    <= 32'h0;
            req_valid_o    <= 1'b0;
            req_addr_o     <= 32'h0;
            req_wdata_o    <= 32'h0;
            req_be_o       <= 4'h0;
            req_is_store_o <= 1'b0;
            tid_cnt        <= '0;
            exp_tid        <= '0;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
`ifdef PICORV_MEM_BRIDGE_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            mem_ready_o <= 1'b0;
            if (rsp_valid_i && !rsp_match) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_valid_i) begin
                        req_addr_o     <= mem_addr_i;
                        req_wdata_o    <= mem_wdata_i;
                        req_is_store_o <= |mem_wstrb_i;
                        req_be_o       <= (|mem_wstrb_i) ? mem_wstrb_i : 4'hF;
                        req_valid_o    <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        exp_tid     <= tid_cnt;
                        tid_cnt     <= tid_cnt + TID_W'(1);
                        req_valid_o <= 1'b0;
                        state       <= WAIT;
`ifdef PICORV_MEM_BRIDGE_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (rsp_match) begin
                        mem_rdata_o <= req_is_store_o ? 32'h0 : rsp_rdata_i;
                        if (rsp_error_i) begin
                            err_o <= 1'b1;
                        end
                        mem_ready_o <= 1'b1;
                        state       <= RESP;
                    end
`ifdef PICORV_MEM_BRIDGE_TIMEOUT_EN
                    // Leaving WAIT retires exp_tid, so a late response is treated as stray.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_rdata_o <= 32'hDEADBEEF;
                        err_o       <= 1'b1;
                        mem_ready_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_mem_bridge.sv
// tb/tb_picorv_mem_bridge.sv - directed and random transactions checked against a transaction-level model.
module tb_picorv_mem_bridge;

    localparam int TID_W = 6;
    localparam int TMO   = 16;
    localparam int LIMIT = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_valid = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_wstrb = '0;
    logic             mem_ready_o;
    logic [31:0]      mem_rdata_o;
    logic             req_valid_o;
    logic             req_ready = 1'b0;
    logic [31:0]      req_addr_o;
    logic [31:0]      req_wdata_o;
    logic [3:0]       req_be_o;
    logic             req_is_store_o;
    logic [TID_W-1:0] req_tid_o;
    logic             rsp_valid = 1'b0;
    logic [TID_W-1:0] rsp_tid = '0;
    logic [31:0]      rsp_rdata = '0;
    logic             rsp_error = 1'b0;
    logic             busy_o;
    logic             err_o;

    int errors = 0;
    int checks = 0;
    int tid_model = 0;
    bit err_model = 1'b0;
    int lat;

    always #5 clk = ~clk;

    picorv_mem_bridge #(.TID_W(TID_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
        .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready), .req_addr_o(req_addr_o),
        .req_wdata_o(req_wdata_o), .req_be_o(req_be_o), .req_is_store_o(req_is_store_o), .req_tid_o(req_tid_o),
        .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid), .rsp_rdata_i(rsp_rdata), .rsp_error_i(rsp_error),
        .busy_o(busy_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        tid_model = 0; err_model = 1'b0;
        #1;
        chk("rst_mem_ready", 32'(mem_ready_o), 0);
        chk("rst_req_valid", 32'(req_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_tid", 32'(req_tid_o), 0);
        chk("rst_addr", req_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One PicoRV32 transaction; the model predicts TID, byte enables, read data, latency and sticky error.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int stall, input bit wrong, input bit no_rsp, input bit drop_valid,
                       input logic [31:0] rd, input bit rerr, output int latency);
        logic [3:0]       e_be;
        logic [31:0]      e_rd;
        logic [TID_W-1:0] e_tid;
        int  stall_left;
        int  rsp_n;
        bit  hs;
        bit  done;
        e_be  = (ws == 4'h0) ? 4'hF : ws;
        e_rd  = no_rsp ? 32'hDEADBEEF : ((ws != 4'h0) ? 32'h0 : rd);
        e_tid = TID_W'(tid_model % (1 << TID_W));
        stall_left = stall; rsp_n = 0; hs = 1'b0; done = 1'b0; latency = -1;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; req_ready = 1'b0;
        for (int c = 1; c <= LIMIT && !done; c++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (mem_ready_o) begin
                done = 1'b1; latency = c;
                mem_valid = 1'b0;
            end else if (hs) begin
                req_ready = 1'b0;
                chk("wait_req_valid", 32'(req_valid_o), 0);
                if (!no_rsp) begin
                    rsp_valid = 1'b1;
                    rsp_tid   = (wrong && rsp_n == 0) ? e_tid + TID_W'(1) : e_tid;
                    rsp_rdata = rd;
                    rsp_error = rerr;
                    rsp_n++;
                end
            end else if (req_valid_o) begin
                if (drop_valid) mem_valid = 1'b0;
                chk("req_addr", req_addr_o, a);
                chk("req_wdata", req_wdata_o, wd);
                chk("req_be", 32'(req_be_o), 32'(e_be));
                chk("req_store", 32'(req_is_store_o), 32'(ws != 4'h0));
                chk("req_tid", 32'(req_tid_o), 32'(e_tid));
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    req_ready = 1'b1; hs = 1'b1; tid_model++;
                end
            end
        end
        chk("txn_done", 32'(done), 1);
        err_model = err_model | rerr | wrong | no_rsp;
        chk("rdata", mem_rdata_o, e_rd);
        chk("err", 32'(err_o), 32'(err_model));
        @(negedge clk);
        chk("ready_pulse", 32'(mem_ready_o), 0);
        chk("idle_busy", 32'(busy_o), 0);
        chk("rdata_hold", mem_rdata_o, e_rd);
    endtask

    initial begin
        logic [TID_W-1:0] stale_tid;
        logic [3:0]       ws;
        int               seen;

        do_reset();

        // Load with immediate handshakes
        txn(32'h100, 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, lat);
        chk("load_latency", 32'(lat), 3);

        // Store with five stalled request cycles
        txn(32'h204, 32'h12345678, 4'b0011, 5, 1'b0, 1'b0, 1'b0, 32'h55AA55AA, 1'b0, lat);
        chk("store_latency", 32'(lat), 8);

        // mem_valid dropped while busy still completes
        txn(32'h300, 32'h0, 4'h0, 1, 1'b0, 1'b0, 1'b1, 32'h0BADC0DE, 1'b0, lat);
        chk("drop_valid_latency", 32'(lat), 4);

        // TID wrap over 65 back-to-back loads from a clean reset
        do_reset();
        for (int i = 0; i < 65; i++) begin
            txn(32'h1000 + 32'(i * 4), 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, lat);
        end
        chk("wrap_next_tid", 32'(req_tid_o), 1);
        chk("wrap_no_err", 32'(err_o), 0);

        // Random loads and stores with random stalls
        for (int i = 0; i < 25; i++) begin
            ws = (($urandom_range(0, 1)) == 0) ? 4'h0 : 4'($urandom);
            txn($urandom, $urandom, ws, $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, $urandom, 1'b0, lat);
        end
        chk("random_no_err", 32'(err_o), 0);

        // Error flagged on a matching response still completes
        txn(32'h400, 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 32'h13579BDF, 1'b1, lat);
        chk("rsp_err_latency", 32'(lat), 3);

        // Wrong TID is dropped, correct one completes
        do_reset();
        txn(32'h500, 32'h0, 4'h0, 0, 1'b1, 1'b0, 1'b0, 32'h2468ACE0, 1'b0, lat);
        chk("wrong_tid_latency", 32'(lat), 4);

`ifdef PICORV_MEM_BRIDGE_TIMEOUT_EN
        do_reset();
        txn(32'h600, 32'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, lat);
        chk("timeout_latency", 32'(lat), 2 + TMO);
`endif

        // Reset while waiting for a response, then a stale response
        do_reset();
        txn(32'h700, 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 32'h89ABCDEF, 1'b0, lat);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h704; mem_wstrb = 4'h0; req_ready = 1'b1;
        @(negedge clk);
        stale_tid = req_tid_o;
        chk("stale_tid", 32'(stale_tid), 1);
        @(negedge clk);
        mem_valid = 1'b0; req_ready = 1'b0;
        chk("wait_busy", 32'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_ready", 32'(mem_ready_o), 0);
        chk("async_req_valid", 32'(req_valid_o), 0);
        chk("async_busy", 32'(busy_o), 0);
        chk("async_err", 32'(err_o), 0);
        chk("async_rdata", mem_rdata_o, 0);
        chk("async_tid", 32'(req_tid_o), 0);
        @(negedge clk);
        rst_n = 1'b1; tid_model = 0; err_model = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1; rsp_tid = stale_tid; rsp_rdata = $urandom; rsp_error = 1'b0;
        seen = 0;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("stale_err", 32'(err_o), 1);
        for (int i = 0; i < 6; i++) begin
            if (mem_ready_o) seen++;
            @(negedge clk);
        end
        chk("stale_no_ready", 32'(seen), 0);
        chk("stale_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picorv_mem_bridge.md
PICORV_MEM_BRIDGE -- requirements
Module: picorv_mem_bridge

Interface
REQ-001 SHALL have parameter TID_W, default 6, width of the transaction ID.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, response watchdog limit in cycles.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports mem_valid_i in 1, mem_addr_i in 32, mem_wdata_i in 32, mem_wstrb_i in 4: PicoRV32 request.
REQ-006 SHALL have ports mem_ready_o out 1, mem_rdata_o out 32: PicoRV32 completion.
REQ-007 SHALL have ports req_valid_o out 1, req_ready_i in 1, req_addr_o out 32, req_wdata_o out 32, req_be_o out 4, req_is_store_o out 1, req_tid_o out TID_W: cache request channel.
REQ-008 SHALL have ports rsp_valid_i in 1, rsp_tid_i in TID_W, rsp_rdata_i in 32, rsp_error_i in 1: cache response channel.
REQ-009 SHALL have ports busy_o out 1 (FSM not IDLE) and err_o out 1 (sticky error).

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-011 IDLE: mem_valid_i=1 SHALL capture addr, wdata, wstrb into registers and go to REQ.
REQ-012 REQ: req_valid_o SHALL be 1, with all req_* outputs driven from the registers and stable until handshake.
REQ-013 req_is_store_o SHALL be 1 iff the captured wstrb is nonzero; req_be_o SHALL be the captured wstrb for stores and 4'hF for loads.
REQ-014 REQ with req_ready_i=1 SHALL record req_tid_o as the expected TID, increment the TID counter modulo 2^TID_W (wrapping to 0), and go to WAIT.
REQ-015 WAIT: rsp_valid_i=1 with rsp_tid_i equal to the expected TID SHALL load mem_rdata_o (rsp_rdata_i for loads, 32'h0 for stores) and go to RESP.
REQ-016 rsp_error_i=1 on a matching response SHALL set err_o and still complete the transaction normally.
REQ-017 A rsp_valid_i with a non-matching TID, or in any state other than WAIT, SHALL be dropped and set err_o.
REQ-018 RESP: mem_ready_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 mem_ready_o SHALL be 0 in every state other than RESP.
REQ-020 Minimum latency: mem_ready_o SHALL assert 3 cycles after the first cycle mem_valid_i is sampled in IDLE (req_ready_i and rsp_valid_i both immediate).
REQ-021 mem_valid_i dropping while busy (protocol violation) SHALL NOT abort; the transaction SHALL complete with a mem_ready_o pulse.
REQ-022 mem_rdata_o SHALL hold its value until the next RESP entry.
REQ-023 At most one transaction SHALL be outstanding; a new request SHALL only be captured in IDLE.

Reset
REQ-024 On rst_ni=0 the block SHALL asynchronously enter IDLE and force mem_ready_o=0, req_valid_o=0, busy_o=0, err_o=0, mem_rdata_o=0, the TID counter to 0, and all request registers to 0.
REQ-025 Reset mid-transaction SHALL discard the transaction; a later stale response SHALL be handled per REQ-017.
REQ-026 err_o SHALL clear only on reset.

Configuration
REQ-027 Macro PICORV_MEM_BRIDGE_TIMEOUT_EN defined: a counter SHALL run in WAIT; reaching TIMEOUT_CYCLES without a matching response SHALL set mem_rdata_o=32'hDEADBEEF, set err_o, and go to RESP.
REQ-028 With that macro, the timed-out TID SHALL be retired; its late response SHALL be dropped per REQ-017.
REQ-029 Macro undefined: there SHALL be no counter and WAIT SHALL persist until a matching response arrives.

Verification
REQ-030 Load: addr 0x100, wstrb 0, ready and response immediate with rdata 0xCAFEF00D -> req_is_store_o=0, req_be_o=F, mem_ready_o pulses 1 cycle 3 cycles after request, mem_rdata_o=0xCAFEF00D.
REQ-031 Store: wstrb 4'b0011, wdata 0x12345678, req_ready_i held 0 for 5 cycles -> req_* stable throughout, req_be_o=3, mem_rdata_o=0 at completion.
REQ-032 TID wrap: 65 back-to-back loads -> req_tid_o sequence 0..63 then 0; no err_o.
REQ-033 Wrong TID: response with tid+1 then correct tid -> first response dropped, err_o=1, completion on second response.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=16): no response -> mem_ready_o after 16 WAIT cycles, mem_rdata_o=0xDEADBEEF, err_o=1.
REQ-035 Reset asserted in WAIT -> all outputs 0 immediately; the following stale response sets err_o with no mem_ready_o pulse.
